id_ex_issue: RTL and testbench

- Decode-to-execute pipeline register and operand issue stage of the RV32 core.
- Captures decoded instructions and resolves register operands via EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and presents in1/in2/alu_op to the ALU with a valid/ready handshake.
- Holds the instruction stable under back-pressure and keeps held operands fresh while stalled.

---
 rtl/id_ex_issue_pkg.sv | 22 ++
 rtl/id_ex_issue_operand_fwd.sv | 37 +++
 rtl/id_ex_issue.sv | 128 ++++++++++++
 tb/tb_id_ex_issue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_issue_pkg.sv
// Shared constants for the ID/EX issue stage: datapath widths and ALU opcode encodings.
package id_ex_issue_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned OP_W_DEF   = 4;

    typedef enum logic [OP_W_DEF-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

endpackage

// File: rtl/id_ex_issue_operand_fwd.sv
// Single-source operand forwarding mux: EX/MEM over MEM/WB over stored data, x0 forced to zero.
module operand_fwd
    import id_ex_issue_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   stored,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   value,
    output logic              memwb_hit,
    output logic              load_hazard
);

    logic exmem_hit;

    always_comb begin
        exmem_hit   = exmem_reg_write && (rs != '0) && (exmem_rd == rs);
        memwb_hit   = memwb_reg_write && (rs != '0) && (memwb_rd == rs);
        load_hazard = exmem_hit && exmem_mem_read;
        value       = stored;
        if (rs == '0)
            value = '0;
        else if (exmem_hit)
            value = exmem_result;
        else if (memwb_hit)
            value = memwb_result;
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with operand forwarding, load-use detection and valid/ready issue to the ALU.
module id_ex_issue
    import id_ex_issue_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_pc,
    input  logic              id_use_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_in1,
    output logic [XLEN-1:0]   ex_in2,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic              load_use_stall
);

    logic              valid_q;
    logic [XLEN-1:0]   pc_q, imm_q, d1_q, d2_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic              use_pc_q, use_imm_q, rw_q;
    logic [OP_W-1:0]   op_q;

    logic [XLEN-1:0]   fwd1, fwd2;
    logic              wb_hit1, wb_hit2, haz1, haz2;
    logic              fire_ex, capture, id_wb1, id_wb2;

    operand_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
        .rs(rs1_q), .stored(d1_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .value(fwd1), .memwb_hit(wb_hit1), .load_hazard(haz1)
    );

    operand_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
        .rs(rs2_q), .stored(d2_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .value(fwd2), .memwb_hit(wb_hit2), .load_hazard(haz2)
    );

    // rs2 is always hazard-checked so stores see a correct ex_store_data.
    assign load_use_stall = valid_q && (haz1 || haz2);
    assign ex_valid       = valid_q && !load_use_stall;
    assign fire_ex        = ex_valid && ex_ready;
    assign id_ready       = !flush && (!valid_q || fire_ex);
    assign capture        = id_valid && id_ready;

    assign id_wb1 = memwb_reg_write && (id_rs1 != '0) && (memwb_rd == id_rs1);
    assign id_wb2 = memwb_reg_write && (id_rs2 != '0) && (memwb_rd == id_rs2);

    assign ex_in1        = use_pc_q ? pc_q : fwd1;
    assign ex_in2        = use_imm_q ? imm_q : fwd2;
    assign ex_store_data = fwd2;
    assign ex_alu_op     = op_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = rw_q;
    assign ex_pc         = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_pc_q  <= 1'b0;
            use_imm_q <= 1'b0;
            rw_q      <= 1'b0;
            op_q      <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            pc_q      <= id_pc;
            imm_q     <= id_imm;
            d1_q      <= id_wb1 ? memwb_result : id_rs1_data;
            d2_q      <= id_wb2 ? memwb_result : id_rs2_data;
            rs1_q     <= id_rs1;
            rs2_q     <= id_rs2;
            rd_q      <= id_rd;
            use_pc_q  <= id_use_pc;
            use_imm_q <= id_use_imm;
            rw_q      <= id_reg_write;
            op_q      <= id_alu_op;
        end else if (fire_ex) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Absorb writebacks while held so the value outlives the forwarding window.
            if (wb_hit1)
                d1_q <= memwb_result;
            if (wb_hit2)
                d2_q <= memwb_result;
        end
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// Scenario-driven self-checking bench for id_ex_issue with an issue-order scoreboard.
module tb_id_ex_issue;
    import id_ex_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_pc, id_use_imm, id_reg_write;
    logic [3:0]  id_alu_op;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, exmem_mem_read, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_ready, ex_reg_write, load_use_stall;
    logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    id_ex_issue #(.XLEN(32), .REG_AW(5), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_pc(ex_pc), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        exmem_rd = '0; exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic upc, input logic uimm, input logic [3:0] op, input logic [4:0] rd);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_use_pc = upc; id_use_imm = uimm; id_alu_op = op; id_rd = rd; id_reg_write = 1'b1;
    endtask

    // Expected ALU view of the offered instruction when no forwarding source is active.
    task automatic sb_push();
        exp_t e;
        e.in1 = id_use_pc ? id_pc : ((id_rs1 == 5'd0) ? 32'd0 : id_rs1_data);
        e.in2 = id_use_imm ? id_imm : ((id_rs2 == 5'd0) ? 32'd0 : id_rs2_data);
        e.pc  = id_pc;
        e.op  = id_alu_op;
        e.rd  = id_rd;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_use_pc = 1'b0; id_use_imm = 1'b0; id_alu_op = '0; id_rd = '0; id_reg_write = 1'b0;
        clear_fwd();
        #2;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
        total++; if (ex_in1 !== 32'd0 || ex_in2 !== 32'd0 || ex_pc !== 32'd0 || ex_rd !== 5'd0 || ex_store_data !== 32'd0)
            begin bad++; $display("FAIL reset_fields in1=%h in2=%h pc=%h rd=%0d sd=%h exp all 0", ex_in1, ex_in2, ex_pc, ex_rd, ex_store_data); end
        total++; if (load_use_stall !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 4'd0)
            begin bad++; $display("FAIL reset_flags stall=%b rw=%b op=%h exp 0", load_use_stall, ex_reg_write, ex_alu_op); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        exp_t e;
        ex_ready = 1'b1;
        drive_id(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd3);
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL add_pre_valid got=%b exp=0", ex_valid); end
        if (id_valid && id_ready) sb_push();
        tick();
        id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_ex_valid got=%b exp=1", ex_valid); end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL add_scoreboard empty, nothing captured"); end
        else begin
            e = sb.pop_front();
            if (ex_in1 !== e.in1 || ex_in2 !== e.in2 || ex_alu_op !== e.op || ex_rd !== e.rd || ex_in1 !== 32'd5 || ex_in2 !== 32'd7)
                begin bad++; $display("FAIL add_result in1=%0d in2=%0d op=%0d rd=%0d exp 5 7 %0d 3", ex_in1, ex_in2, ex_alu_op, ex_rd, ALU_ADD); end
        end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", ex_valid); end
    endtask

    task automatic test_fwd_priority();
        ex_ready = 1'b0;
        drive_id(32'h200, 5'd4, 5'd5, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0, ALU_OR, 5'd6);
        tick();
        id_valid = 1'b0;
        exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
        memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
        #1;
        total++; if (ex_in1 !== 32'hAA) begin bad++; $display("FAIL fwd_exmem got=%h exp=aa", ex_in1); end
        exmem_reg_write = 1'b0;
        #1;
        total++; if (ex_in1 !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=bb", ex_in1); end
        clear_fwd();
        #1;
        total++; if (ex_in1 !== 32'h11) begin bad++; $display("FAIL fwd_stored got=%h exp=11", ex_in1); end
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        drive_id(32'h204, 5'd0, 5'd5, 32'h99, 32'h22, 32'd0, 1'b0, 1'b0, ALU_OR, 5'd6);
        tick();
        id_valid = 1'b0;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
        #1;
        total++; if (ex_in1 !== 32'd0) begin bad++; $display("FAIL fwd_x0 got=%h exp=0", ex_in1); end
        clear_fwd();
        ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1;
        drive_id(32'h300, 5'd6, 5'd7, 32'd1, 32'd2, 32'h40, 1'b0, 1'b1, ALU_ADD, 5'd8);
        tick();
        id_valid = 1'b0;
        exmem_rd = 5'd6; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 32'hDEAD;
        #1;
        total++; if (load_use_stall !== 1'b1 || ex_valid !== 1'b0 || id_ready !== 1'b0)
            begin bad++; $display("FAIL lu_stall stall=%b valid=%b ready=%b exp 1 0 0", load_use_stall, ex_valid, id_ready); end
        tick();
        clear_fwd();
        memwb_rd = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h1234;
        #1;
        total++; if (ex_in1 !== 32'h1234 || ex_valid !== 1'b1 || load_use_stall !== 1'b0)
            begin bad++; $display("FAIL lu_release in1=%h valid=%b stall=%b exp 1234 1 0", ex_in1, ex_valid, load_use_stall); end
        total++; if (ex_in2 !== 32'h40) begin bad++; $display("FAIL lu_imm got=%h exp=40", ex_in2); end
        tick();
        clear_fwd();
    endtask

    task automatic test_backpressure_refresh();
        ex_ready = 1'b0;
        drive_id(32'h400, 5'd8, 5'd9, 32'd3, 32'd4, 32'h7FF, 1'b0, 1'b0, ALU_SUB, 5'd10);
        tick();
        id_valid = 1'b0;
        memwb_rd = 5'd9; memwb_reg_write = 1'b1; memwb_result = 32'h55;
        #1;
        total++; if (ex_in2 !== 32'h55) begin bad++; $display("FAIL bp_cycle1 in2=%h exp=55", ex_in2); end
        tick();
        clear_fwd();
        #1;
        total++; if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin bad++; $display("FAIL bp_hold valid=%b ready=%b exp 1 0", ex_valid, id_ready); end
        tick();
        #1;
        total++; if (ex_in2 !== 32'h55 || ex_store_data !== 32'h55)
            begin bad++; $display("FAIL bp_refresh in2=%h sd=%h exp 55 55", ex_in2, ex_store_data); end
        total++; if (ex_pc !== 32'h400 || ex_alu_op !== ALU_SUB || ex_in1 !== 32'd3 || ex_rd !== 5'd10)
            begin bad++; $display("FAIL bp_stable pc=%h op=%0d in1=%0d rd=%0d exp 400 1 3 10", ex_pc, ex_alu_op, ex_in1, ex_rd); end
        ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        drive_id(32'h500, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, ALU_XOR, 5'd11);
        tick();
        flush = 1'b1;
        drive_id(32'h504, 5'd3, 5'd4, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, ALU_AND, 5'd12);
        #1;
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_id_ready got=%b exp=0", id_ready); end
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid); end
        total++; if (ex_pc === 32'h504 || ex_rd === 5'd12) begin bad++; $display("FAIL flush_nocapture pc=%h rd=%0d exp not 504/12", ex_pc, ex_rd); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_after got=%b exp=0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cnt   = 0;
        int   first = -1;
        int   last  = -1;
        ex_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8)
                drive_id(32'h600 + 32'(c * 4), 5'd1, 5'd2, 32'(c * 3), 32'(c + 100), 32'd0,
                         1'b0, 1'b0, 4'(c), 5'(c + 1));
            else
                id_valid = 1'b0;
            #1;
            if (ex_valid && ex_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL stream_pop cycle=%0d scoreboard empty", c); end
                else begin
                    e = sb.pop_front();
                    if (ex_in1 !== e.in1 || ex_in2 !== e.in2 || ex_pc !== e.pc || ex_alu_op !== e.op || ex_rd !== e.rd)
                        begin bad++; $display("FAIL stream_data cycle=%0d got pc=%h in1=%h in2=%h op=%h rd=%0d exp pc=%h in1=%h in2=%h op=%h rd=%0d",
                                              c, ex_pc, ex_in1, ex_in2, ex_alu_op, ex_rd, e.pc, e.in1, e.in2, e.op, e.rd); end
                end
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            if (id_valid && id_ready) sb_push();
            tick();
        end
        total++; if (cnt != 8 || first != 1 || last != 8)
            begin bad++; $display("FAIL stream_count cnt=%0d first=%0d last=%0d exp 8 1 8", cnt, first, last); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_leftover got=%0d exp=0", sb.size()); end

        for (int c = 0; c < 3; c++) begin
            drive_id(32'h700 + 32'(c * 4), 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd3);
            tick();
        end
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", ex_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_pc !== 32'd0)
            begin bad++; $display("FAIL midrst_drop valid=%b ready=%b pc=%h exp 0 1 0", ex_valid, id_ready, ex_pc); end
        id_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_fwd_priority();
        test_load_use();
        test_backpressure_refresh();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
